// File: rtl/mdu_pkg.sv
// mdu_pkg: operation codes and op classification for the multiply/divide unit.
// Optional feature macro: MDU_MADD_EN (enables madd/maddu/msub/msubu).
package mdu_pkg;

    typedef enum logic [3:0] {
        MDU_NONE  = 4'd0,
        MDU_MULT  = 4'd1,
        MDU_MULTU = 4'd2,
        MDU_DIV   = 4'd3,
        MDU_DIVU  = 4'd4,
        MDU_MFHI  = 4'd5,
        MDU_MFLO  = 4'd6,
        MDU_MTHI  = 4'd7,
        MDU_MTLO  = 4'd8,
        MDU_MADD  = 4'd9,
        MDU_MADDU = 4'd10,
        MDU_MSUB  = 4'd11,
        MDU_MSUBU = 4'd12
    } mdu_op_e;

    // What an accepted issue does to the unit's state
    typedef enum logic [2:0] {
        KIND_NONE = 3'd0,
        KIND_MULT = 3'd1,
        KIND_DIV  = 3'd2,
        KIND_MTHI = 3'd3,
        KIND_MTLO = 3'd4
    } op_kind_e;

    // Multiply-accumulate ops share the multiply latency; without the
    // feature they fall through to KIND_NONE and are ignored.
    function automatic op_kind_e mdu_op_kind(input logic [3:0] op);
        case (op)
            MDU_MULT, MDU_MULTU: return KIND_MULT;
`ifdef MDU_MADD_EN
            MDU_MADD, MDU_MADDU, MDU_MSUB, MDU_MSUBU: return KIND_MULT;
`endif
            MDU_DIV, MDU_DIVU: return KIND_DIV;
            MDU_MTHI:          return KIND_MTHI;
            MDU_MTLO:          return KIND_MTLO;
            default:           return KIND_NONE;
        endcase
    endfunction

endpackage

// File: rtl/mdu_if.sv
// mdu_if: issue/read bundle between the EX stage (master) and the mdu (slave).
interface mdu_if;
    logic [31:0] srcA;
    logic [31:0] srcB;
    logic [3:0]  mduOp;
    logic        start;
    logic        busy;
    logic [31:0] outHL;

    modport master (output srcA, output srcB, output mduOp, output start,
                    input busy, input outHL);
    modport slave  (input srcA, input srcB, input mduOp, input start,
                    output busy, output outHL);
endinterface

// File: rtl/mdu_calc.sv
// mdu_calc: combinational {HI,LO} result for mult/div (and madd family when
// MDU_MADD_EN is defined). Ops that produce nothing return the current {HI,LO}.
import mdu_pkg::*;

module mdu_calc (
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [31:0] hi,
    input  logic [31:0] lo,
    output logic [63:0] res
);
    logic signed [63:0] a_sx;
    logic signed [63:0] b_sx;
    logic signed [63:0] prod_s;
    logic        [63:0] a_zx;
    logic        [63:0] b_zx;
    logic        [63:0] prod_u;

    logic signed [31:0] a_s;
    logic signed [31:0] b_safe_s;
    logic signed [31:0] q_s;
    logic signed [31:0] r_s;
    logic        [31:0] b_safe_u;
    logic        [31:0] q_u;
    logic        [31:0] r_u;
    logic               div_zero;
    logic               div_ovf;

    assign a_sx   = {{32{a[31]}}, a};
    assign b_sx   = {{32{b[31]}}, b};
    assign prod_s = a_sx * b_sx;
    assign a_zx   = {32'd0, a};
    assign b_zx   = {32'd0, b};
    assign prod_u = a_zx * b_zx;

    // Divisor is forced to 1 on the special cases so the dividers never see
    // a zero divisor or the overflowing INT_MIN / -1 pair.
    assign div_zero = (b == 32'd0);
    assign div_ovf  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    assign a_s      = $signed(a);
    assign b_safe_s = (div_zero || div_ovf) ? 32'sd1 : $signed(b);
    assign q_s      = a_s / b_safe_s;
    assign r_s      = a_s % b_safe_s;
    assign b_safe_u = div_zero ? 32'd1 : b;
    assign q_u      = a / b_safe_u;
    assign r_u      = a % b_safe_u;

    // Result select; signed / and % truncate toward zero with the remainder
    // following the dividend's sign, which is the MIPS behaviour.
    always_comb begin
        res = {hi, lo};
        case (op)
            MDU_MULT:  res = $unsigned(prod_s);
            MDU_MULTU: res = prod_u;
            MDU_DIV: begin
                if (div_zero)
                    res = {a, 32'hFFFF_FFFF};
                else if (div_ovf)
                    res = {32'd0, 32'h8000_0000};
                else
                    res = {$unsigned(r_s), $unsigned(q_s)};
            end
            MDU_DIVU: begin
                if (div_zero)
                    res = {a, 32'hFFFF_FFFF};
                else
                    res = {r_u, q_u};
            end
`ifdef MDU_MADD_EN
            MDU_MADD:  res = {hi, lo} + $unsigned(prod_s);
            MDU_MADDU: res = {hi, lo} + prod_u;
            MDU_MSUB:  res = {hi, lo} - $unsigned(prod_s);
            MDU_MSUBU: res = {hi, lo} - prod_u;
`endif
            default:   res = {hi, lo};
        endcase
    end

endmodule

// File: rtl/mdu.sv
// mdu: multi-cycle multiply/divide unit owning HI/LO. Latency is modelled by
// a busy counter; the result is computed at issue and committed on expiry.
// Optional feature macro: MDU_MADD_EN (madd/maddu/msub/msubu).
import mdu_pkg::*;

module mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input logic  clk,
    input logic  reset,
    mdu_if.slave bus
);
    localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [CNT_W-1:0] count;
    logic [63:0]      pend_p1;
    logic [31:0]      hi;
    logic [31:0]      lo;
    logic [0:0]       state;
    logic             accept;
    op_kind_e         kind;
    logic [63:0]      calc_res;
    logic [31:0]      rd_data;

    // The state is fully described by the counter: RUN while it is non-zero
    assign state  = (count != '0) ? ST_RUN : ST_IDLE;
    assign accept = bus.start && (state == ST_IDLE);
    assign kind   = mdu_op_kind(bus.mduOp);

    mdu_calc u_calc (
        .op  (bus.mduOp),
        .a   (bus.srcA),
        .b   (bus.srcB),
        .hi  (hi),
        .lo  (lo),
        .res (calc_res)
    );

    // Issue, count down and commit; issues arriving while RUN are dropped
    always_ff @(posedge clk) begin
        if (reset) begin
            count   <= '0;
            pend_p1 <= '0;
            hi      <= '0;
            lo      <= '0;
        end else if (state == ST_RUN) begin
            count <= count - CNT_W'(1);
            if (count == CNT_W'(1)) begin
                {hi, lo} <= pend_p1;
            end
        end else if (accept) begin
            case (kind)
                KIND_MULT: begin
                    pend_p1 <= calc_res;
                    count   <= CNT_W'(MULT_CYCLES);
                end
                KIND_DIV: begin
                    pend_p1 <= calc_res;
                    count   <= CNT_W'(DIV_CYCLES);
                end
                KIND_MTHI: hi <= bus.srcA;
                KIND_MTLO: lo <= bus.srcA;
                default: ;
            endcase
        end
    end

    // Read port: always the committed HI/LO, never the pending result
    always_comb begin
        rd_data = 32'd0;
        if (bus.mduOp == MDU_MFHI)
            rd_data = hi;
        else if (bus.mduOp == MDU_MFLO)
            rd_data = lo;
    end

    assign bus.outHL = rd_data;
    assign bus.busy  = (state == ST_RUN);

endmodule

// File: doc/mdu.md
# mdu

Multi-cycle multiply/divide unit for the pipelined MIPS core, sitting in EX beside the single-cycle ALU. It accepts an issued mult/div/move-to operation, owns the HI and LO registers, and models iterative latency with a busy counter. The hazard unit stalls dependent instructions while `busy` is high.

## Interface
- `MULT_CYCLES`, default 5: busy cycles for mult/multu (and madd-family when enabled); must be ≥1.
- `DIV_CYCLES`, default 10: busy cycles for div/divu; must be ≥1.

- `clk`  in  1  clock; all state on rising edge.
- `reset`  in  1  synchronous, active-high.
- `srcA`  in  32  operand rs (dividend / multiplicand / mthi-mtlo data).
- `srcB`  in  32  operand rt (divisor / multiplier).
- `mduOp`  in  4  operation code (`MDU_*` from `head.v`).
- `start`  in  1  issue strobe; qualifies every state-changing op.
- `busy`  out  1  high while a mult/div is in flight.
- `outHL`  out  32  combinational read: HI for `MDU_mfhi`, LO for `MDU_mflo`, else 0.

## Operation
- Op codes: none=0, mult=1, multu=2, div=3, divu=4, mfhi=5, mflo=6, mthi=7, mtlo=8, madd=9, maddu=10, msub=11, msubu=12.
- Issue accepted only when `start`=1 and `busy`=0; `start` during `busy` is ignored, with no state change.
- mult/multu: 64-bit product of srcA×srcB (signed/unsigned); HI=upper 32 bits, LO=lower 32 bits.
- div/divu: LO=quotient, HI=remainder. Signed division truncates toward zero; remainder takes the dividend's sign.
- Divisor 0: LO=32'hFFFF_FFFF, HI=srcA.
- Signed 32'h8000_0000 / 32'hFFFF_FFFF: LO=32'h8000_0000, HI=0.
- Result is computed from operands latched at issue into a pending {HI,LO} register, then committed when the counter expires.
- mthi/mtlo: write HI/LO with srcA at the issue edge; zero latency; busy stays low.
- mfhi/mflo: read-only, no `start` needed. They return the committed value even while busy; stalling reads is the hazard unit's job.
- States: IDLE (count=0) and RUN (count≠0). IDLE→RUN on accepted mult/div. RUN→IDLE on the edge where count==1, which commits pending HI/LO.

## Timing
- Reset values: HI=0, LO=0, count=0, pending=0; so `busy`=0 and `outHL`=0.
- Mult/div issued in cycle t: `busy` is high in cycles t+1..t+N (N = `MULT_CYCLES` or `DIV_CYCLES`).
- New HI/LO is visible on `outHL` from cycle t+N+1.
- `busy` is registered; it is not high in the issue cycle. The hazard unit stalls on `busy` OR (`start` with a mult/div op).
- mthi/mtlo issued in cycle t: new value is readable from cycle t+1.
- Back-to-back: a new mult/div can be accepted in cycle t+N+1.
- Reset mid-RUN: the counter clears, the pending result is discarded, and HI/LO go to 0 on that edge.
- Unknown or none op with `start`: ignored.

## Configuration
- `MDU_MADD_EN` defined:
  - madd/maddu/msub/msubu supported with `MULT_CYCLES` latency.
  - {HI,LO} ± product, computed mod 2^64 from the HI/LO value at issue.
- `MDU_MADD_EN` undefined: op codes 9–12 are treated as none and ignored.

## Structure
- `head.v` holds the `MDU_*` op-code macros and the `MDU_MADD_EN` switch, alongside the existing `ALU_*` codes.
- Sub-module `mdu_calc` is pure combinational. It maps (mduOp, srcA, srcB, HI, LO) to a 64-bit {HI,LO} result and covers all division special cases.
- The top level holds the counter, pending register, HI/LO registers and the read mux.

## Test plan
- After reset, `mflo`/`mfhi` → `outHL`=0. Then `mtlo` 0x1234 → `mflo` reads 0x1234 the next cycle, and `busy` never rises.
- `mult` with A=0xFFFFFFFF, B=2 → `busy` high 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFE. `multu` with the same operands → HI=1, LO=0xFFFFFFFE.
- `div` with A=-7, B=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF after 10 busy cycles. `divu` with A=7, B=2 → LO=3, HI=1.
- `div` with A=5, B=0 → LO=0xFFFFFFFF, HI=5. `div` with A=0x80000000, B=0xFFFFFFFF → LO=0x80000000, HI=0.
- Second `start` (mtlo 9) issued during busy → ignored, and the final LO equals the mult result. `reset` asserted at busy cycle 3 → `busy`=0, HI=LO=0 the next cycle.
- With `MDU_MADD_EN`: HI=0, LO=0xFFFFFFFF, then `maddu` 1×1 → HI=1, LO=0. Without `MDU_MADD_EN`: HI/LO unchanged and `busy` stays low.
